// File: rtl/pad_ctrl_pkg.sv
// pad_ctrl_pkg -- shared constants and types for the APB pad controller.
//   PAD_BASE / IN_BASE : byte base addresses of the PADn and INk register windows.
//   PADCFG_W           : pad-configuration width of this pad frame (bit 0 = pull enable).
//   func_e             : function-select encoding (0 = dedicated sysio, 1 = GPIO).
//   padreg_t           : stored contents of one PADn register, laid out as read back.
package pad_ctrl_pkg;

  localparam logic [11:0] PAD_BASE = 12'h000;
  localparam logic [11:0] IN_BASE  = 12'h400;
  localparam int          PADCFG_W = 6;

  typedef enum logic [1:0] {
    FUNC_SYSIO = 2'd0,
    FUNC_GPIO  = 2'd1,
    FUNC_ALT2  = 2'd2,
    FUNC_ALT3  = 2'd3
  } func_e;

  // Field order matches the register layout: sel in [1:0], cfg above it.
  typedef struct packed {
    logic [PADCFG_W-1:0] cfg;
    func_e               sel;
  } padreg_t;

endpackage

// File: rtl/pad_sync2.sv
// pad_sync2 -- parameterised-width two-flop synchroniser.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears both stages
//   d_i   : asynchronous input bits
//   q_o   : synchronised bits, two rising edges after d_i settles
module pad_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // NOTE: non-blocking assignments make s2 take the old s1, giving a real two-stage chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/apb_pad_ctrl.sv
// apb_pad_ctrl -- register-programmable pad mux and pad configuration.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   apb_*                 : zero-wait-state APB slave (PADn RW at 0x000+4n, INk RO at 0x400+4k)
//   func_out_i/func_oe_i  : N_FUNC source vectors of N_IO bits, source f at [f*N_IO +: N_IO]
//   func_in_o             : synchronised pad inputs, shared by all functions
//   io_out_o/io_oe_o      : pad data / output enable, selected per pad by PADn.sel
//   io_in_i               : asynchronous pad inputs
//   pad_cfg_o             : PADn.cfg for pad n at [n*NBIT_PADCFG +: NBIT_PADCFG]
// NBIT_PADCFG must equal pad_ctrl_pkg::PADCFG_W; the stored register type is sized from it.
module apb_pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int N_IO        = 61,
  parameter int NBIT_PADCFG = PADCFG_W,
  parameter int N_FUNC      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        apb_psel_i,
  input  logic                        apb_penable_i,
  input  logic                        apb_pwrite_i,
  input  logic [11:0]                 apb_paddr_i,
  input  logic [31:0]                 apb_pwdata_i,
  output logic [31:0]                 apb_prdata_o,
  output logic                        apb_pready_o,
  output logic                        apb_pslverr_o,
  input  logic [N_FUNC*N_IO-1:0]      func_out_i,
  input  logic [N_FUNC*N_IO-1:0]      func_oe_i,
  output logic [N_IO-1:0]             func_in_o,
  output logic [N_IO-1:0]             io_out_o,
  output logic [N_IO-1:0]             io_oe_o,
  input  logic [N_IO-1:0]             io_in_i,
  output logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_o
);

  localparam int N_IN      = (N_IO + 31) / 32;
  localparam int PAD_IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam int IN_IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [9:0] PAD_WBASE = PAD_BASE[11:2];
  localparam logic [9:0] IN_WBASE  = IN_BASE[11:2];
  localparam logic [9:0] N_IO_W    = 10'(N_IO);
  localparam logic [9:0] N_IN_W    = 10'(N_IN);

  padreg_t           pad_q [N_IO];
  logic [N_IO-1:0]   sync_q;

  // ---------------------------------------------------------------------------
  // Address decode. Offsets wrap below their base, so a single upper-bound
  // compare per window rejects addresses on both sides of it.
  // ---------------------------------------------------------------------------
  logic [9:0]           addr_w;
  logic [9:0]           pad_word;
  logic [9:0]           in_word;
  logic                 pad_hit;
  logic                 in_hit;
  logic                 access;
  logic                 wr_pad;
  logic [PAD_IDX_W-1:0] pad_idx;
  logic [IN_IDX_W-1:0]  in_idx;

  assign addr_w   = apb_paddr_i[11:2];
  assign pad_word = addr_w - PAD_WBASE;
  assign in_word  = addr_w - IN_WBASE;
  assign pad_hit  = (pad_word < N_IO_W);
  assign in_hit   = (in_word < N_IN_W);
  assign pad_idx  = pad_word[PAD_IDX_W-1:0];
  assign in_idx   = in_word[IN_IDX_W-1:0];
  assign access   = apb_psel_i & apb_penable_i;
  assign wr_pad   = access & apb_pwrite_i & pad_hit;

  // Byte-lane bits and pwdata above the stored fields carry no information.
  logic unused_bits;
  assign unused_bits = ^{apb_paddr_i[1:0], apb_pwdata_i[31:2+NBIT_PADCFG]};

  // ---------------------------------------------------------------------------
  // PADn registers. Reset wins over a write in the same cycle.
  // ---------------------------------------------------------------------------
  // NOTE: the register array is reset entry by entry; it drives pads directly, so it is flops, not a RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < N_IO; n++) begin
        pad_q[n] <= '{cfg: '0, sel: FUNC_SYSIO};
      end
    end else if (wr_pad) begin
      pad_q[pad_idx] <= '{cfg: apb_pwdata_i[2 +: NBIT_PADCFG],
                          sel: func_e'(apb_pwdata_i[1:0])};
    end
  end

  // ---------------------------------------------------------------------------
  // Input path.
  // ---------------------------------------------------------------------------
  pad_sync2 #(.WIDTH(N_IO)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (io_in_i),
    .q_o   (sync_q)
  );

  assign func_in_o = sync_q;

  // INk words, zero-padded past the last pad.
  logic [N_IN*32-1:0] in_flat;
  logic [31:0]        in_words [N_IN];

  always_comb begin
    in_flat           = '0;
    in_flat[N_IO-1:0] = sync_q;
    for (int k = 0; k < N_IN; k++) begin
      in_words[k] = in_flat[k*32 +: 32];
    end
  end

  // ---------------------------------------------------------------------------
  // APB read data / error, combinational during the access phase.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this always_comb gets a default first so no path infers a latch.
  always_comb begin
    apb_prdata_o  = '0;
    apb_pslverr_o = 1'b0;
    if (access) begin
      if (pad_hit) begin
        if (!apb_pwrite_i) begin
          apb_prdata_o[NBIT_PADCFG+1:0] = pad_q[pad_idx];
        end
      end else if (in_hit && !apb_pwrite_i) begin
        apb_prdata_o = in_words[in_idx];
      end else begin
        apb_pslverr_o = 1'b1;
      end
    end
  end

  assign apb_pready_o = 1'b1;

  // ---------------------------------------------------------------------------
  // Per-pad function mux and configuration outputs.
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < N_IO; n++) begin : g_pad
    logic [N_FUNC-1:0] out_opts;
    logic [N_FUNC-1:0] oe_opts;

    for (genvar f = 0; f < N_FUNC; f++) begin : g_func
      assign out_opts[f] = func_out_i[f*N_IO + n];
      assign oe_opts[f]  = func_oe_i[f*N_IO + n];
    end

    assign io_out_o[n] = out_opts[pad_q[n].sel];
    assign io_oe_o[n]  = oe_opts[pad_q[n].sel];
    assign pad_cfg_o[n*NBIT_PADCFG +: NBIT_PADCFG] = pad_q[n].cfg;
  end

endmodule

// File: tb/tb_apb_pad_ctrl.sv
// tb_apb_pad_ctrl -- self-checking bench for apb_pad_ctrl: directed cases
// followed by randomized APB traffic and pad activity, all compared against
// a register-map / delay-line reference model.
module tb_apb_pad_ctrl;

  localparam int N_IO  = 61;
  localparam int W     = 6;
  localparam int NF    = 4;
  localparam int N_IN  = 2;
  localparam int LOG_N = 1024;

  logic                clk = 1'b0;
  logic                rst_i;
  logic                psel, penable, pwrite;
  logic [11:0]         paddr;
  logic [31:0]         pwdata;
  logic [31:0]         prdata;
  logic                pready, pslverr;
  logic [NF*N_IO-1:0]  func_out, func_oe;
  logic [N_IO-1:0]     func_in, io_out, io_oe, io_in;
  logic [N_IO*W-1:0]   pad_cfg;

  apb_pad_ctrl #(.N_IO(N_IO), .NBIT_PADCFG(W), .N_FUNC(NF)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .apb_psel_i    (psel),
    .apb_penable_i (penable),
    .apb_pwrite_i  (pwrite),
    .apb_paddr_i   (paddr),
    .apb_pwdata_i  (pwdata),
    .apb_prdata_o  (prdata),
    .apb_pready_o  (pready),
    .apb_pslverr_o (pslverr),
    .func_out_i    (func_out),
    .func_oe_i     (func_oe),
    .func_in_o     (func_in),
    .io_out_o      (io_out),
    .io_oe_o       (io_oe),
    .io_in_i       (io_in),
    .pad_cfg_o     (pad_cfg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: register file as stored bytes, and a log of io_in as seen
  // at each rising edge (func_in is the value logged two edges back).
  // ---------------------------------------------------------------------------
  logic [7:0]      pad_m  [N_IO];
  logic [N_IO-1:0] in_log [LOG_N];
  int              cyc      = 0;
  int              last_rst = -1;

  // 0 = PADn, 1 = readable INk, 2 = error
  function automatic int decode(input logic [11:0] a, input bit wr, output int idx);
    int w;
    w   = int'(a) >> 2;
    idx = 0;
    if (w < N_IO) begin
      idx = w;
      return 0;
    end
    if (w >= 256 && w - 256 < N_IN && !wr) begin
      idx = w - 256;
      return 1;
    end
    return 2;
  endfunction

  function automatic logic [N_IO-1:0] exp_sync();
    if (cyc - 2 <= last_rst) return '0;
    return in_log[(cyc - 2) % LOG_N];
  endfunction

  function automatic logic [N_IO-1:0] exp_mux(input logic [NF*N_IO-1:0] src);
    logic [N_IO-1:0] r;
    for (int n = 0; n < N_IO; n++) r[n] = src[int'(pad_m[n][1:0]) * N_IO + n];
    return r;
  endfunction

  function automatic logic [N_IO*W-1:0] exp_cfg();
    logic [N_IO*W-1:0] r;
    for (int n = 0; n < N_IO; n++) r[n*W +: W] = pad_m[n][7:2];
    return r;
  endfunction

  always @(posedge clk) begin : model
    int idx;
    in_log[cyc % LOG_N] <= io_in;
    cyc <= cyc + 1;
    if (rst_i) begin
      last_rst <= cyc;
      for (int n = 0; n < N_IO; n++) pad_m[n] <= '0;
    end else if (psel && penable && pwrite && decode(paddr, 1'b1, idx) == 0) begin
      pad_m[idx] <= pwdata[7:0];
    end
  end

  // Continuous output comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("io_out",   384'(io_out),  384'(exp_mux(func_out)));
      check("io_oe",    384'(io_oe),   384'(exp_mux(func_oe)));
      check("pad_cfg",  384'(pad_cfg), 384'(exp_cfg()));
      check("func_in",  384'(func_in), 384'(exp_sync()));
      check("pready",   384'(pready),  384'(1'b1));
    end
  end

  // ---------------------------------------------------------------------------
  // APB transfer: setup then access; leaves psel high so a following call is
  // a back-to-back transfer. Optional reset asserted in the access cycle.
  // ---------------------------------------------------------------------------
  task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                     input bit rst_mid, output logic [31:0] rdata);
    int          idx, kind;
    logic [31:0] exp_rd;
    logic [63:0] in_all;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge clk);
    #1;
    penable = 1'b1;
    if (rst_mid) rst_i = 1'b1;
    @(negedge clk);
    kind   = decode(addr, wr, idx);
    exp_rd = '0;
    if (!wr && kind == 0) exp_rd = {24'b0, pad_m[idx]};
    if (kind == 1) begin
      in_all = {3'b0, exp_sync()};
      exp_rd = 32'(in_all >> (32 * idx));
    end
    rdata = prdata;
    check("pslverr", 384'(pslverr), 384'(kind == 2));
    if (!wr || kind == 2) check("prdata", 384'(prdata), 384'(exp_rd));
    @(posedge clk);
    #1;
    penable = 1'b0;
    if (rst_mid) rst_i = 1'b0;
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NF*N_IO-1:0] rnd_func();
    logic [NF*N_IO-1:0] r;
    for (int i = 0; i < NF*N_IO; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [N_IO-1:0] rnd_in();
    logic [N_IO-1:0] r;
    for (int i = 0; i < N_IO; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [11:0] a;
    int          pick;

    rst_i    = 1'b1;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    func_out = '0;
    func_oe  = '0;
    io_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i  = 1'b0;
    chk_en = 1'b1;

    // Reset state: PAD5 and IN0 read 0, pads follow function 0, cfg 0.
    func_oe  = rnd_func();
    func_out = rnd_func();
    idle(2);
    apb(1'b0, 12'h014, '0, 1'b0, rd);
    check("rst_pad5", 384'(rd), 384'(0));
    apb(1'b0, 12'h400, '0, 1'b0, rd);
    check("rst_in0", 384'(rd), 384'(0));
    @(negedge clk);
    check("rst_oe_f0",  384'(io_oe),   384'(func_oe[N_IO-1:0]));
    check("rst_cfg0",   384'(pad_cfg), 384'(0));
    idle(1);

    // PAD20 = sel 2, cfg 1.
    func_out = '0;
    func_oe  = '0;
    func_out[2*N_IO + 20] = 1'b1;
    func_oe[2*N_IO + 20]  = 1'b1;
    apb(1'b1, 12'h050, 32'h0000_0006, 1'b0, rd);
    @(negedge clk);
    check("pad20_out", 384'(io_out[20]),           384'(1'b1));
    check("pad20_oe",  384'(io_oe[20]),            384'(1'b1));
    check("pad20_cfg", 384'(pad_cfg[20*W +: W]),   384'(6'h01));
    apb(1'b0, 12'h050, '0, 1'b0, rd);
    check("pad20_rd",  384'(rd), 384'(32'h06));
    idle(1);

    // io_in[33] rises: visible two edges later, not one.
    io_in[33] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sync_t1", 384'(func_in[33]), 384'(1'b0));
    @(negedge clk);
    check("sync_t2", 384'(func_in[33]), 384'(1'b1));
    @(posedge clk);
    #1;
    apb(1'b0, 12'h404, '0, 1'b0, rd);
    check("in1_bit1", 384'(rd[1]), 384'(1'b1));

    // Error accesses: write to IN1, read past the last pad.
    apb(1'b1, 12'h404, 32'hFFFF_FFFF, 1'b0, rd);
    apb(1'b0, 12'h3F0, '0, 1'b0, rd);
    check("err_rd_zero", 384'(rd), 384'(0));
    apb(1'b0, 12'h050, '0, 1'b0, rd);
    check("pad20_kept", 384'(rd), 384'(32'h06));

    // Only sel and cfg bits are stored.
    apb(1'b1, 12'h000, 32'hFFFF_FFFF, 1'b0, rd);
    apb(1'b0, 12'h000, '0, 1'b0, rd);
    check("pad0_mask", 384'(rd), 384'(32'hFF));

    // Back-to-back write then read of the same pad.
    apb(1'b1, 12'h00C, 32'h0000_00A9, 1'b0, rd);
    apb(1'b0, 12'h00C, '0, 1'b0, rd);
    check("b2b_pad3", 384'(rd), 384'(32'hA9));
    idle(1);

    // Reset in the access cycle of a write to PAD7: write discarded.
    apb(1'b1, 12'h01C, 32'h0000_0005, 1'b1, rd);
    idle(1);
    apb(1'b0, 12'h01C, '0, 1'b0, rd);
    check("pad7_rst", 384'(rd), 384'(0));
    func_out = rnd_func();
    @(negedge clk);
    check("pad7_f0", 384'(io_out[7]), 384'(func_out[7]));
    idle(1);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      func_out = rnd_func();
      func_oe  = rnd_func();
      if ($urandom_range(0, 2) == 0) io_in = rnd_in();
      pick = $urandom_range(0, 9);
      if (pick < 7)
        a = 12'($urandom_range(0, N_IO - 1) * 4 + $urandom_range(0, 3));
      else if (pick == 7)
        a = 12'(12'h400 + $urandom_range(0, 2) * 4 + $urandom_range(0, 3));
      else
        a = 12'($urandom_range(0, 4095));
      apb(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 49) == 0), rd);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
